uart_rx: RTL
============

// Module: uart_rx
// PURPOSE
//  Asynchronous serial receiver, 8N1, LSB first; receive-side companion of the uart transmitter.
//  Samples rs232_rxd at mid-bit and emits each received byte as a 1-cycle strobe to the consumer.
//  Default timing is 921600 baud from a 50 MHz clk.
//  No backpressure: the consumer must capture rx_byte in the rx_valid cycle.
// PARAMETERS
//  CLKS_PER_BIT  54  clk cycles per bit; must be >= 8
//  CNT_W         9   bit-timer width; 2**CNT_W > CLKS_PER_BIT
//  SYNC_STAGES   2   synchroniser flops on rs232_rxd; must be >= 2
// PORTS
//  clk        in   1  system clock; all logic on posedge
//  rst        in   1  asynchronous, active-high reset
//  rs232_rxd  in   1  raw serial line; idles high
//  rx_byte    out  8  last received byte; held until the next good byte
//  rx_valid   out  1  1-cycle strobe: rx_byte updated with a good frame
//  frame_err  out  1  1-cycle strobe: stop bit sampled low
//  busy       out  1  high in every state except IDLE
// BEHAVIOUR
//  Reset values: rx_byte=0, rx_valid=0, frame_err=0, busy=0, state=IDLE, all synchroniser flops=1.
//  Reset mid-frame: the partial byte is discarded with no strobe; the receiver re-arms on the next falling edge.
//  rxd_s is rs232_rxd after SYNC_STAGES flops. All sampling uses rxd_s, never the raw pin.
//  Bit timer: cnt[CNT_W-1:0] is cleared on every state change and wraps to 0 at CLKS_PER_BIT-1.
//  Define MID = CLKS_PER_BIT/2 - 1 and FULL = CLKS_PER_BIT-1.
//  State machine:
//   IDLE   - rxd_s==0 -> START, cnt=0.
//   START  - at cnt==MID sample the line.
//            Sample 0 -> DATA: cnt=0, bit_idx=0, the timer is now aligned to mid-bit.
//            Sample 1 -> IDLE (glitch rejected, no strobe).
//   DATA   - at cnt==FULL sample into shift[bit_idx] (LSB first) and increment bit_idx.
//            After bit_idx==7 is sampled -> STOP.
//   STOP   - at cnt==FULL sample the stop bit.
//            Sample 1 -> rx_byte<=shift and rx_valid=1 on the next cycle; go to IDLE.
//            Sample 0 -> frame_err=1 on the next cycle; rx_byte is unchanged; go to BREAK.
//   BREAK  - wait for rxd_s==1, then -> IDLE. A held-low line (break) produces exactly one frame_err.
//  Back-to-back frames: a start edge is accepted in the first cycle after returning to IDLE.
//  No dead time is required between frames.
//  Latency: rx_valid rises 1 cycle after the stop-bit mid-point sample.
//  That is ~SYNC_STAGES + 9.5*CLKS_PER_BIT cycles after the raw start edge.
//  rx_valid and frame_err are never high together; each is high for exactly 1 cycle.
// CONFIGURATION
//  UART_RX_MAJORITY_EN defined:
//   each data/stop sample is the 2-of-3 majority of rxd_s at sample-1, sample, sample+1.
//   The START check also uses majority.
//   Output timing is unchanged: the decision is registered at sample+1 and every later event shifts by +1 cycle.
//  UART_RX_MAJORITY_EN undefined:
//   single sample of rxd_s at the sample point.
//   A 1-cycle glitch exactly on the sample point corrupts that bit.
// STRUCTURE
//  Shared header uart_defs.vh: UART_CLKS_PER_BIT ('d54), UART_DATA_BITS (8), and the state encodings
//   RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK as 3-bit localparams.
//   The transmitter takes its bit time from the same header so both ends cannot drift apart.
//  Sub-module sync_ff:
//   SYNC_STAGES-deep flop chain with reset value 1 and async active-high rst.
//   Reusable by other async inputs.
//  The bit timer uses the existing counter module (W=CNT_W, FINAL_VAL=CLKS_PER_BIT-1).
// TESTING
//  1. Drive 0xA5 8N1 at 54 clk/bit -> exactly one rx_valid pulse with rx_byte=0xA5; frame_err stays 0.
//  2. Drive 0x00 then 0xFF back-to-back, no idle gap -> two rx_valid pulses, rx_byte 0x00 then 0xFF.
//     The pulses are 10*54 cycles apart.
//  3. Pull the line low for 10 cycles in IDLE -> no strobe; busy drops within MID+SYNC_STAGES+2 cycles.
//  4. Drive 0x3C with stop bit 0, hold low 2000 cycles -> one frame_err pulse, no rx_valid, rx_byte unchanged.
//     busy stays high until the line returns high.
//  5. Assert rst mid bit 4 of 0x5A, release, then send 0x81 -> no strobe for 0x5A; rx_valid with 0x81.
//  6. With UART_RX_MAJORITY_EN: send 0x0F with a 1-cycle high glitch at the mid-point of bit 5.
//     Expect rx_byte=0x0F. Without the macro, expect 0x2F.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: the bit time, the data width and the receiver state encodings.
// Latency: none, because this file holds constants and a pure function only.
// Backpressure: not applicable. The transmitter takes its bit time from here so both ends agree.
package uart_rx_pkg;

    // Default bit time is 921600 baud from a 50 MHz clock.
    localparam int UART_CLKS_PER_BIT = 'd54;
    localparam int UART_DATA_BITS    = 8;

    // Receiver states. These are plain 3-bit constants so older code that compares raw values keeps working.
    localparam logic [2:0] RX_IDLE  = 3'd0;
    localparam logic [2:0] RX_START = 3'd1;
    localparam logic [2:0] RX_DATA  = 3'd2;
    localparam logic [2:0] RX_STOP  = 3'd3;
    localparam logic [2:0] RX_BREAK = 3'd4;

    // 2-of-3 vote, used when the line is majority filtered.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/counter.sv
// Free-running up counter. It wraps to 0 after FINAL_VAL and has a synchronous clear.
// Latency: the count and the last flag are registered and change on the clk edge after clr or en.
// Backpressure: none; the en input pauses the count.
module counter #(
    parameter int W         = 9,
    parameter int FINAL_VAL = 53
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         last
);

    localparam logic [W-1:0] FINAL_W = W'(FINAL_VAL);

    // Count up. Wrap after the final value. Clear has priority so callers can realign the count at any time.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            if (cnt == FINAL_W) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + W'(1);
            end
        end
    end

    assign last = (cnt == FINAL_W);

endmodule

// File: rtl/sync_ff.sv
// Multi-flop synchroniser for one asynchronous input. The flops reset to 1, the idle level of a serial line.
// Latency: STAGES clk cycles from pin to q.
// Backpressure: none; it samples every cycle.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // Shift the raw input through the flop chain. The oldest value exits at the top.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= '1;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, sampling at mid-bit. Define UART_RX_MAJORITY_EN to use a 2-of-3 majority vote per sample.
// Latency: rx_valid rises 1 cycle after the stop-bit sample, about SYNC_STAGES + 9.5*CLKS_PER_BIT cycles after the start edge (+1 with majority).
// Backpressure: none. rx_valid and frame_err are single-cycle strobes and the consumer must capture rx_byte at once.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int CNT_W        = 9,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rs232_rxd,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       busy
);

    // MID is half a bit after the start edge. FULL is the last count of one whole bit.
    localparam logic [CNT_W-1:0] MID      = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]       LAST_BIT = 3'(UART_DATA_BITS - 1);

    logic             rxd_s;
    logic             line;
    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             cnt_last;
    logic             state_chg;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rs232_rxd),
        .q   (rxd_s)
    );

`ifdef UART_RX_MAJORITY_EN
    // The filtered line votes over the current synchronised sample and the two samples before it.
    // Each decision is therefore centred one cycle earlier than the cycle in which it is made,
    // so every event moves one cycle later without changing the bit timing.
    logic rxd_d1;
    logic rxd_d2;

    // Keep two older samples of the synchronised line for the vote.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxd_d1 <= 1'b1;
            rxd_d2 <= 1'b1;
        end else begin
            rxd_d1 <= rxd_s;
            rxd_d2 <= rxd_d1;
        end
    end

    assign line = maj3(rxd_s, rxd_d1, rxd_d2);
`else
    // Without majority, the decisions use the synchronised line directly.
    assign line = rxd_s;
`endif

    // The bit timer clears on every state change. START begins on the first low cycle, so the MID
    // sample falls in the centre of the start bit. From then on each FULL wrap lands on a bit centre.
    assign state_chg = (state_nxt != state);

    counter #(
        .W         (CNT_W),
        .FINAL_VAL (CLKS_PER_BIT - 1)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (state_chg),
        .en   (1'b1),
        .cnt  (cnt),
        .last (cnt_last)
    );

    // Next-state decision for the frame sequencer.
    always_comb begin
        state_nxt = state;
        case (state)
            RX_IDLE: begin
                if (!line) begin
                    state_nxt = RX_START;
                end
            end
            RX_START: begin
                // A start bit that is high again at its centre was a glitch.
                if (cnt == MID) begin
                    state_nxt = line ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_last && (bit_idx == LAST_BIT)) begin
                    state_nxt = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt_last) begin
                    state_nxt = line ? RX_IDLE : RX_BREAK;
                end
            end
            RX_BREAK: begin
                // Stay here until the line is released, so a held-low line reports one error only.
                if (line) begin
                    state_nxt = RX_IDLE;
                end
            end
            default: state_nxt = RX_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RX_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Shift the data bits in LSB first at each bit centre.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_idx <= 3'd0;
            shift   <= 8'd0;
        end else begin
            if ((state == RX_START) && (state_nxt == RX_DATA)) begin
                bit_idx <= 3'd0;
            end else if ((state == RX_DATA) && cnt_last) begin
                shift[bit_idx] <= line;
                bit_idx        <= bit_idx + 3'd1;
            end
        end
    end

    // Check the stop bit. A good stop bit publishes the byte; a low stop bit raises the error strobe only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_byte   <= 8'd0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            if ((state == RX_STOP) && cnt_last) begin
                if (line) begin
                    rx_byte  <= shift;
                    rx_valid <= 1'b1;
                end else begin
                    frame_err <= 1'b1;
                end
            end
        end
    end

    assign busy = (state != RX_IDLE);

endmodule
